// File: rtl/fa_norm_pack_if.sv
// Handshake bundle between the adder summation stage, fa_norm_pack and its consumer.
// master drives the input channel and out_ready; slave is the normalize/pack block.
interface fa_norm_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_ex;
    logic [23:0] in_sum;
    logic        in_ov;
    logic [4:0]  in_count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    modport master (
        output in_valid, in_sign, in_ex, in_sum, in_ov, in_count, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_ex, in_sum, in_ov, in_count, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fa_norm_pack.sv
// Two-stage normalize-and-pack of a float adder result into IEEE-754 single (truncating).
// Define FA_EXC_FLAGS_EN to drive out_flags; without it out_flags is tied to 3'b000.
module fa_norm_pack (
    input  logic          CLK,
    input  logic          RESETn,
    fa_norm_pack_if.slave bus
);
    typedef enum logic [1:0] {CLS_SPECIAL, CLS_CARRY, CLS_ZERO, CLS_NORMAL} cls_e;

    logic        s1_valid_reg;
    cls_e        s1_cls_reg;
    cls_e        cls_next;
    logic        s1_sign_reg;
    logic [23:0] s1_sum_reg;
    logic [4:0]  s1_sh_reg;
    logic [4:0]  sh_next;
    logic [7:0]  s1_exp_reg;
    logic [8:0]  exp_next;
    logic        s1_of_reg;
    logic        of_next;
    logic        s1_uf_reg;
    logic        uf_next;
    logic        out_valid_reg;
    logic [31:0] out_result_reg;
    logic [31:0] result_next;
    logic [22:0] frac_norm;
    logic [8:0]  ex9;
    logic        s1_load;
    logic        s2_load;

    assign s2_load        = !out_valid_reg || bus.out_ready;
    assign s1_load        = !s1_valid_reg || s2_load;
    assign bus.in_ready   = s1_load;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_result = out_result_reg;

    assign ex9     = {1'b0, bus.in_ex};
    assign sh_next = 5'd23 - bus.in_count;

    always_comb begin
        cls_next = CLS_NORMAL;
        if (bus.in_ex == 8'hFF)
            cls_next = CLS_SPECIAL;
        else if (bus.in_ov)
            cls_next = CLS_CARRY;
        else if (bus.in_sum == 24'h0)
            cls_next = CLS_ZERO;
    end

    // 9-bit exponent: a negative or zero difference shows up as bit 8 set or all-zero low bits.
    assign exp_next = (cls_next == CLS_CARRY) ? ex9 + 9'd1 : ex9 - {4'b0, sh_next};
    assign of_next  = exp_next >= 9'd255;
    assign uf_next  = exp_next[8] || (exp_next[7:0] == 8'h00);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_valid_reg <= 1'b0;
            s1_cls_reg   <= CLS_ZERO;
            s1_sign_reg  <= 1'b0;
            s1_sum_reg   <= 24'h0;
            s1_sh_reg    <= 5'd0;
            s1_exp_reg   <= 8'h00;
            s1_of_reg    <= 1'b0;
            s1_uf_reg    <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= bus.in_valid;
            s1_cls_reg   <= cls_next;
            s1_sign_reg  <= bus.in_sign;
            s1_sum_reg   <= bus.in_sum;
            s1_sh_reg    <= sh_next;
            s1_exp_reg   <= exp_next[7:0];
            s1_of_reg    <= of_next;
            s1_uf_reg    <= uf_next;
        end
    end

    // Only the 23 fraction bits survive, so the hidden one can be dropped before shifting.
    assign frac_norm = s1_sum_reg[22:0] << s1_sh_reg;

    always_comb begin
        result_next = 32'h0000_0000;
        case (s1_cls_reg)
            CLS_SPECIAL: result_next = {s1_sign_reg, 8'hFF, s1_sum_reg[22:0]};
            CLS_CARRY: begin
                if (s1_of_reg)
                    result_next = {s1_sign_reg, 8'hFF, 23'h0};
                else
                    result_next = {s1_sign_reg, s1_exp_reg, s1_sum_reg[23:1]};
            end
            CLS_ZERO: result_next = 32'h0000_0000;
            default: begin
                if (s1_uf_reg)
                    result_next = {s1_sign_reg, 31'h0};
                else
                    result_next = {s1_sign_reg, s1_exp_reg, frac_norm};
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= 32'h0000_0000;
        end else if (s2_load) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg)
                out_result_reg <= result_next;
        end
    end

`ifdef FA_EXC_FLAGS_EN
    logic [2:0] flags_next;
    logic [2:0] out_flags_reg;

    always_comb begin
        flags_next = 3'b000;
        case (s1_cls_reg)
            CLS_CARRY:  flags_next = {2'b00, s1_of_reg};
            CLS_ZERO:   flags_next = 3'b100;
            CLS_NORMAL: flags_next = {s1_uf_reg, s1_uf_reg, 1'b0};
            default:    flags_next = 3'b000;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            out_flags_reg <= 3'b000;
        else if (s2_load && s1_valid_reg)
            out_flags_reg <= flags_next;
    end

    assign bus.out_flags = out_flags_reg;
`else
    assign bus.out_flags = 3'b000;
`endif
endmodule

// File: tb/tb_fa_norm_pack.sv
// Randomized and directed bench for fa_norm_pack against an arithmetic reference model.
module tb_fa_norm_pack;
    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    always #5 CLK = ~CLK;

    fa_norm_pack_if bus ();

    fa_norm_pack dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int n_out = 0;
    bit rand_mode = 0;
    logic [34:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [4:0] lead_idx(input logic [23:0] m);
        logic [4:0] p;
        p = 5'd23;
        if (m != 24'h0) begin
            for (int i = 0; i < 24; i++)
                if (m[i]) p = 5'(i);
        end
        return p;
    endfunction

    // Reference: value-level normalization; returns {flags, result}.
    function automatic logic [34:0] ref_pack(input logic s, input logic [7:0] ex,
                                             input logic [23:0] m, input logic ov);
        int          e;
        int          p;
        int          sh;
        longint      frac;
        logic [31:0] r;
        logic [2:0]  f;
        e = int'(ex);
        r = 32'h0;
        f = 3'b000;
        frac = 0;
        if (e == 255) begin
            r = {s, 8'hFF, m[22:0]};
        end else if (ov) begin
            if (e + 1 >= 255) begin
                r = {s, 8'hFF, 23'h0};
                f = 3'b001;
            end else begin
                r = {s, 8'(e + 1), m[23:1]};
            end
        end else if (m == 24'h0) begin
            f = 3'b100;
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++)
                if (m[i]) p = i;
            sh = 23 - p;
            if (e > sh) begin
                frac = (longint'(m) * (longint'(1) << sh)) % (longint'(1) << 23);
                r = {s, 8'(e - sh), frac[22:0]};
            end else begin
                r = {s, 31'h0};
                f = 3'b110;
            end
        end
`ifndef FA_EXC_FLAGS_EN
        f = 3'b000;
`endif
        return {f, r};
    endfunction

    // Monitor: decides transfers at the falling edge, ahead of the rising edge that commits them.
    initial begin
        logic        hold_pending;
        logic [34:0] held;
        logic [34:0] want;
        hold_pending = 1'b0;
        held = 35'h0;
        forever begin
            @(negedge CLK);
            if (!RESETn) begin
                exp_q.delete();
                hold_pending = 1'b0;
            end else begin
                if (hold_pending && bus.out_valid)
                    check_eq("hold_stable", {bus.out_flags, bus.out_result}, held);
                hold_pending = bus.out_valid && !bus.out_ready;
                held = {bus.out_flags, bus.out_result};
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("out_unexpected", bus.out_valid, 1'b0);
                    end else begin
                        want = exp_q.pop_front();
                        check_eq("out_order", {bus.out_flags, bus.out_result}, want);
                        $display("out #%0d: result=%08h flags=%03b expect=%08h/%03b",
                                 n_out, bus.out_result, bus.out_flags, want[31:0], want[34:32]);
                        n_out++;
                    end
                end
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(ref_pack(bus.in_sign, bus.in_ex, bus.in_sum, bus.in_ov));
            end
        end
    end

    task automatic set_in(input logic s, input logic [7:0] e, input logic [23:0] m, input logic o);
        bus.in_sign  = s;
        bus.in_ex    = e;
        bus.in_sum   = m;
        bus.in_ov    = o;
        bus.in_count = lead_idx(m);
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m, input logic o);
        bit ok;
        ok = 0;
        set_in(s, e, m, o);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge CLK);
            if (bus.in_ready) ok = 1;
            @(posedge CLK);
            #1;
            if (rand_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid = 1'b0;
        check_eq("in_accept", ok, 1'b1);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic dir_case(input string tag, input logic s, input logic [7:0] e,
                            input logic [23:0] m, input logic o,
                            input logic [31:0] res, input logic [2:0] flg);
        logic [2:0] want_f;
        want_f = flg;
`ifndef FA_EXC_FLAGS_EN
        want_f = 3'b000;
`endif
        bus.out_ready = 1'b1;
        send(s, e, m, o);
        @(negedge CLK);
        check_eq({tag, "_lat1"}, bus.out_valid, 1'b0);
        @(negedge CLK);
        check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
        check_eq({tag, "_result"}, bus.out_result, res);
        check_eq({tag, "_flags"}, bus.out_flags, want_f);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0]  e;
        logic [23:0] m;
        logic        s;
        logic        o;
        int          k;
        int          p;
        int          acc;
        int          n0;
        logic [7:0]  sv_ex[3];
        logic [23:0] sv_sum[3];
        bit          ok;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 8'h00, 24'h0, 1'b0);

        #12;
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_result", bus.out_result, 32'h0);
        check_eq("rst_out_flags", bus.out_flags, 3'b000);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        @(negedge CLK);
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge CLK);
        #1;

        dir_case("unity",    1'b0, 8'h80, 24'h800000, 1'b0, 32'h40000000, 3'b000);
        dir_case("carry",    1'b0, 8'h80, 24'h800000, 1'b1, 32'h40C00000, 3'b000);
        dir_case("carry_of", 1'b0, 8'hFE, 24'h800000, 1'b1, 32'h7F800000, 3'b001);
        dir_case("norm23",   1'b0, 8'h85, 24'h000001, 1'b0, 32'h37000000, 3'b000);
        dir_case("uflow",    1'b1, 8'h05, 24'h000100, 1'b0, 32'h80000000, 3'b110);
        dir_case("zero",     1'b1, 8'h40, 24'h000000, 1'b0, 32'h00000000, 3'b100);
        dir_case("special",  1'b0, 8'hFF, 24'h400001, 1'b0, 32'h7FC00001, 3'b000);

        rand_mode = 1;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            s = 1'($urandom_range(0, 1));
            e = 8'($urandom);
            o = ($urandom_range(0, 4) == 0);
            p = $urandom_range(0, 23);
            m = (24'($urandom) >> (23 - p)) | (24'(1) << p);
            if (k == 0) m = 24'h0;
            if (k == 1) e = 8'hFF;
            if (k == 2) e = 8'($urandom_range(0, 25));
            if (k == 3) begin
                e = 8'($urandom_range(250, 254));
                o = 1'b1;
            end
            send(s, e, m, o);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        rand_mode = 0;
        drain();

        // Back-pressure: only two results fit while the consumer stalls.
        sv_ex  = '{8'h81, 8'h90, 8'h7A};
        sv_sum = '{24'h812345, 24'h00F00F, 24'h3ABCDE};
        n0 = n_out;
        acc = 0;
        bus.out_ready = 1'b0;
        set_in(1'b0, sv_ex[0], sv_sum[0], 1'b0);
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            if (bus.in_ready) acc++;
            @(posedge CLK);
            #1;
            if (acc < 3) set_in(1'b0, sv_ex[acc], sv_sum[acc], 1'b0);
        end
        check_eq("stall_accepted", acc, 2);
        @(negedge CLK);
        check_eq("stall_in_ready", bus.in_ready, 1'b0);
        @(posedge CLK);
        #1;
        bus.out_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge CLK);
            if (bus.in_ready) ok = 1;
            @(posedge CLK);
            #1;
        end
        bus.in_valid = 1'b0;
        check_eq("stall_third_accept", ok, 1'b1);
        drain();
        check_eq("stall_emerged", n_out - n0, 3);

        // Reset with two results in flight.
        bus.out_ready = 1'b0;
        send(1'b0, 8'h80, 24'h800000, 1'b0);
        send(1'b1, 8'h82, 24'hC00000, 1'b0);
        RESETn = 1'b0;
        #1;
        check_eq("midrst_out_valid", bus.out_valid, 1'b0);
        check_eq("midrst_out_result", bus.out_result, 32'h0);
        check_eq("midrst_out_flags", bus.out_flags, 3'b000);
        repeat (2) @(posedge CLK);
        #1;
        RESETn = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            check_eq("postrst_out_valid", bus.out_valid, 1'b0);
        end
        check_eq("postrst_in_ready", bus.in_ready, 1'b1);
        check_eq("postrst_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
